// File: rtl/ov7670_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ov7670_stream_gen
//  Description : OV7670-style RGB444 video transmitter (PCLK/VSYNC/HREF/D)
//                carrying a selectable test pattern (bars, solid, checker, box).
//  Revision    : 1.0 - initial release
// ============================================================================
module ov7670_stream_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10,
  parameter int BOX_X0      = 288,
  parameter int BOX_Y0      = 208,
  parameter int BOX_W       = 64,
  parameter int BOX_H       = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [11:0] solid_rgb,
  output logic        pclk,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  d,
  output logic        busy,
  output logic        frame_done
);

  localparam int C_L      = 2 * H_ACTIVE + H_BLANK;
  localparam int C_HBYTES = 2 * H_ACTIVE;
  localparam int C_BAR_W  = H_ACTIVE / 8;
  localparam int C_M1     = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int C_M2     = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int C_MAXL   = (C_M1 > C_M2) ? C_M1 : C_M2;
  localparam int C_BW     = $clog2(C_L);
  localparam int C_LW     = $clog2(C_MAXL + 1);
  localparam int C_RW     = $clog2(C_BAR_W + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_VBACK  = 3'd2,
    S_ACTIVE = 3'd3,
    S_VFRONT = 3'd4
  } state_t;

  state_t            r_state;
  logic [C_BW-1:0]   r_byte;
  logic [C_LW-1:0]   r_line;
  logic [C_RW-1:0]   r_run;
  logic [2:0]        r_bar;
  logic [1:0]        r_pat;
  logic [11:0]       r_rgb;

  state_t            w_state_nx;
  logic [C_BW-1:0]   w_byte_nx;
  logic [C_LW-1:0]   w_line_nx;
  logic [C_LW-1:0]   w_lines_m1;
  logic              w_last_byte;
  logic              w_last_line;
  logic [C_RW-1:0]   w_run_nx;
  logic [2:0]        w_bar_nx;
  logic [31:0]       w_x;
  logic [31:0]       w_y;
  logic [11:0]       w_pix;
  logic              w_href_nx;
  logic [7:0]        w_d_nx;

  // Number of line periods (minus one) spent in the current state
  always_comb begin
    w_lines_m1 = '0;
    case (r_state)
      S_VSYNC:  w_lines_m1 = C_LW'(VSYNC_LINES - 1);
      S_VBACK:  w_lines_m1 = C_LW'(V_BACK - 1);
      S_ACTIVE: w_lines_m1 = C_LW'(V_ACTIVE - 1);
      S_VFRONT: w_lines_m1 = C_LW'(V_FRONT - 1);
      default:  w_lines_m1 = '0;
    endcase
  end

  // Position and state of the byte that follows the one currently presented
  always_comb begin
    w_state_nx  = r_state;
    w_byte_nx   = r_byte + 1'b1;
    w_line_nx   = r_line;
    w_last_byte = (r_byte == C_BW'(C_L - 1));
    w_last_line = (r_line == w_lines_m1);
    if (w_last_byte) begin
      w_byte_nx = '0;
      if (w_last_line) begin
        w_line_nx = '0;
        case (r_state)
          S_VSYNC:  w_state_nx = S_VBACK;
          S_VBACK:  w_state_nx = S_ACTIVE;
          S_ACTIVE: w_state_nx = S_VFRONT;
          S_VFRONT: w_state_nx = enable ? S_VSYNC : S_IDLE;
          default:  w_state_nx = S_IDLE;
        endcase
      end else begin
        w_line_nx = r_line + 1'b1;
      end
    end
  end

  // Colour-bar index tracked by a per-pixel run counter rather than a divide
  always_comb begin
    w_run_nx = r_run;
    w_bar_nx = r_bar;
    if (w_byte_nx == '0) begin
      w_run_nx = '0;
      w_bar_nx = '0;
    end else if (!w_byte_nx[0] && (w_byte_nx < C_BW'(C_HBYTES))) begin
      if (r_run == C_RW'(C_BAR_W - 1)) begin
        w_run_nx = '0;
        w_bar_nx = r_bar + 1'b1;
      end else begin
        w_run_nx = r_run + 1'b1;
      end
    end
  end

  // Pattern colour and output byte for the next byte period
  always_comb begin
    w_x   = 32'(w_byte_nx >> 1);
    w_y   = 32'(w_line_nx);
    w_pix = 12'h000;
    case (r_pat)
      2'd0: begin
        case (w_bar_nx)
          3'd0: w_pix = 12'hFFF;
          3'd1: w_pix = 12'hFF0;
          3'd2: w_pix = 12'h0FF;
          3'd3: w_pix = 12'h0F0;
          3'd4: w_pix = 12'hF0F;
          3'd5: w_pix = 12'hF00;
          3'd6: w_pix = 12'h00F;
          default: w_pix = 12'h000;
        endcase
      end
      2'd1: w_pix = r_rgb;
      2'd2: w_pix = (w_x[5] ^ w_y[5]) ? 12'hFFF : 12'h000;
      default: begin
        if ((w_x >= 32'(BOX_X0)) && (w_x < 32'(BOX_X0 + BOX_W)) &&
            (w_y >= 32'(BOX_Y0)) && (w_y < 32'(BOX_Y0 + BOX_H)))
          w_pix = r_rgb;
      end
    endcase
    w_href_nx = (w_state_nx == S_ACTIVE) && (w_byte_nx < C_BW'(C_HBYTES));
    w_d_nx    = 8'h00;
    if (w_href_nx)
      w_d_nx = w_byte_nx[0] ? w_pix[7:0] : {4'h0, w_pix[11:8]};
  end

  // Frame FSM: pclk phase, counters and registered video outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_byte     <= '0;
      r_line     <= '0;
      r_run      <= '0;
      r_bar      <= '0;
      r_pat      <= '0;
      r_rgb      <= '0;
      pclk       <= 1'b0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      d          <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (r_state == S_IDLE) begin
        pclk  <= 1'b0;
        vsync <= 1'b0;
        href  <= 1'b0;
        d     <= 8'h00;
        busy  <= 1'b0;
        if (enable) begin
          r_state <= S_VSYNC;
          r_byte  <= '0;
          r_line  <= '0;
          r_run   <= '0;
          r_bar   <= '0;
          r_pat   <= pattern_sel;
          r_rgb   <= solid_rgb;
          vsync   <= 1'b1;
          busy    <= 1'b1;
        end
      end else if (!pclk) begin
        // Second half of the byte period; flag the very last byte of the frame
        pclk <= 1'b1;
        if ((r_state == S_VFRONT) && w_last_byte && w_last_line)
          frame_done <= 1'b1;
      end else begin
        // Falling pclk: advance to the next byte and update the video outputs
        pclk    <= 1'b0;
        r_state <= w_state_nx;
        r_byte  <= w_byte_nx;
        r_line  <= w_line_nx;
        r_run   <= w_run_nx;
        r_bar   <= w_bar_nx;
        if ((r_state == S_VFRONT) && (w_state_nx == S_VSYNC)) begin
          r_pat <= pattern_sel;
          r_rgb <= solid_rgb;
        end
        if (w_state_nx == S_IDLE) begin
          vsync <= 1'b0;
          href  <= 1'b0;
          d     <= 8'h00;
          busy  <= 1'b0;
        end else begin
          vsync <= (w_state_nx == S_VSYNC);
          href  <= w_href_nx;
          d     <= w_d_nx;
          busy  <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ov7670_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ov7670_stream_gen
//  Description : Scoreboard bench for ov7670_stream_gen using reduced frame
//                geometry and a frame-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ov7670_stream_gen;

  localparam int HA = 64, VA = 36, HB = 10, VSL = 2, VBK = 2, VFR = 2;
  localparam int BX0 = 20, BY0 = 10, BW = 16, BH = 12;
  localparam int L = 2 * HA + HB;
  localparam int TOT_LINES = VSL + VBK + VA + VFR;
  localparam int FRAME_CLKS = TOT_LINES * L * 2;
  localparam int MID = (VSL + VBK + VA / 2) * L * 2;

  logic clk = 1'b0;
  logic rst_n, enable;
  logic [1:0] pattern_sel;
  logic [11:0] solid_rgb;
  logic pclk, vsync, href, busy, frame_done;
  logic [7:0] d;

  int n_cmp = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  typedef struct packed {
    logic       vs;
    logic       hr;
    logic [7:0] dd;
    logic       last;
  } exp_t;
  exp_t q[$];

  ov7670_stream_gen #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .VSYNC_LINES(VSL),
    .V_BACK(VBK), .V_FRONT(VFR), .BOX_X0(BX0), .BOX_Y0(BY0),
    .BOX_W(BW), .BOX_H(BH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
    .solid_rgb(solid_rgb), .pclk(pclk), .vsync(vsync), .href(href), .d(d),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ref_pixel(input int x, input int y,
                                            input int pat, input logic [11:0] rgb);
    int bar;
    logic [11:0] c;
    c = 12'h000;
    case (pat)
      0: begin
        bar = x / (HA / 8);
        case (bar)
          0: c = 12'hFFF; 1: c = 12'hFF0; 2: c = 12'h0FF; 3: c = 12'h0F0;
          4: c = 12'hF0F; 5: c = 12'hF00; 6: c = 12'h00F; default: c = 12'h000;
        endcase
      end
      1: c = rgb;
      2: c = ((((x / 32) % 2) != ((y / 32) % 2))) ? 12'hFFF : 12'h000;
      default: c = (x >= BX0 && x < BX0 + BW && y >= BY0 && y < BY0 + BH) ? rgb : 12'h000;
    endcase
    return c;
  endfunction

  // Expected byte stream of one whole frame, pushed onto the scoreboard
  task automatic push_frame(input int pat, input logic [11:0] rgb);
    exp_t e;
    logic [11:0] px;
    bit act;
    for (int ln = 0; ln < TOT_LINES; ln++) begin
      for (int b = 0; b < L; b++) begin
        act  = (ln >= VSL + VBK) && (ln < VSL + VBK + VA);
        e.vs = (ln < VSL);
        e.hr = act && (b < 2 * HA);
        e.dd = 8'h00;
        if (e.hr) begin
          px   = ref_pixel(b / 2, ln - VSL - VBK, pat, rgb);
          e.dd = (b % 2 == 1) ? px[7:0] : {4'h0, px[11:8]};
        end
        e.last = (ln == TOT_LINES - 1) && (b == L - 1);
        q.push_back(e);
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every pclk-high cycle presents one byte, popped from the scoreboard
  initial begin
    logic prev_pclk, prev_busy;
    exp_t e;
    prev_pclk = 1'b0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n) begin
        if (busy && prev_busy)
          check("pclk_toggle", {31'd0, pclk}, {31'd0, ~prev_pclk});
        if (pclk) begin
          if (q.size() == 0) begin
            check("unexpected_byte", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            check("byte", {20'd0, busy, vsync, href, d, frame_done},
                  {20'd0, 1'b1, e.vs, e.hr, e.dd, e.last});
          end
        end else begin
          check("frame_done_low", {31'd0, frame_done}, 32'd0);
        end
      end
      prev_pclk = pclk;
      prev_busy = busy;
    end
  end

  task automatic check_idle(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check(name, {20'd0, pclk, vsync, href, d, busy, frame_done}, 32'd0);
    end
  endtask

  initial begin
    int cnt;
    bit got;
    int pats[4];
    logic [11:0] rgbs[4];

    rst_n = 1'b0; enable = 1'b0; pattern_sel = 2'd0; solid_rgb = 12'h000;
    repeat (3) @(negedge clk);
    check("reset_outputs", {20'd0, pclk, vsync, href, d, busy, frame_done}, 32'd0);
    rst_n = 1'b1;
    check_idle("idle_after_reset", 200);

    pats[0] = 0; rgbs[0] = 12'($urandom);
    pats[1] = 2; rgbs[1] = 12'($urandom);
    pats[2] = 3; rgbs[2] = 12'hF00;
    pats[3] = 1; rgbs[3] = 12'($urandom);

    mon_en = 1'b1;
    pattern_sel = 2'(pats[0]);
    solid_rgb   = rgbs[0];
    push_frame(pats[0], rgbs[0]);
    enable = 1'b1;
    @(negedge clk);
    check("start_latency", {29'd0, vsync, busy, pclk}, {29'd0, 3'b110});

    for (int f = 0; f < 4; f++) begin
      cnt = 0;
      got = 1'b0;
      while (!got && cnt < FRAME_CLKS + 50) begin
        @(negedge clk);
        cnt++;
        if (cnt == MID) begin
          // Mid-ACTIVE change: only the following frame may pick this up
          if (f < 3) begin
            pattern_sel = 2'(pats[f + 1]);
            solid_rgb   = rgbs[f + 1];
            push_frame(pats[f + 1], rgbs[f + 1]);
          end else begin
            enable      = 1'b0;
            pattern_sel = 2'($urandom);
            solid_rgb   = 12'($urandom);
          end
        end
        if (frame_done) got = 1'b1;
      end
      check("frame_done_seen", {31'd0, got}, 32'd1);
      check("frame_length", cnt + 1, FRAME_CLKS);
      @(negedge clk);
      if (f < 3)
        check("back_to_back_vsync", {30'd0, vsync, busy}, {30'd0, 2'b11});
      else
        check("stop_after_frame", {30'd0, vsync, busy}, 32'd0);
    end

    check_idle("idle_after_stop", 300);
    check("scoreboard_drained", q.size(), 32'd0);

    // Asynchronous reset in the middle of an active line
    mon_en = 1'b0;
    pattern_sel = 2'd0;
    enable = 1'b1;
    cnt = 0;
    while (!href && cnt < FRAME_CLKS) begin
      @(negedge clk);
      cnt++;
    end
    check("href_before_reset", {31'd0, href}, 32'd1);
    repeat (51) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {20'd0, pclk, vsync, href, d, busy, frame_done}, 32'd0);
    check_idle("held_in_reset", 10);
    enable = 1'b0;
    rst_n = 1'b1;
    check_idle("idle_after_release", 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
